// File: rtl/trig_gen.sv
// Trigger generator for the signal analyzer: masked value match, level/edge qualification, occurrence count, post-match delay.
// Optional cycle timestamp of the fire moment is built when TRIG_TIMESTAMP_EN is defined; otherwise trig_time reads 0.
module trig_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] probe,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic [DATA_WIDTH-1:0] match_val,
  input  logic [DATA_WIDTH-1:0] match_mask,
  input  logic                  edge_mode,
  input  logic [CNT_WIDTH-1:0]  count_target,
  input  logic [CNT_WIDTH-1:0]  delay,
  output logic                  trigger,
  output logic                  armed,
  output logic                  fired,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [31:0]           trig_time
);

  typedef enum logic [1:0] {IDLE, ARMED, DELAY, FIRED} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   probe_q_reg;
  logic                    arm_q_reg;
  logic                    match_prev_reg;
  logic [DATA_WIDTH-1:0]   match_val_l_reg;
  logic [DATA_WIDTH-1:0]   match_mask_l_reg;
  logic                    edge_mode_l_reg;
  logic [CNT_WIDTH-1:0]    count_target_l_reg;
  logic [CNT_WIDTH-1:0]    delay_l_reg;
  logic [CNT_WIDTH-1:0]    dly_cnt_reg, dly_cnt_next;
  logic [CNT_WIDTH-1:0]    hit_count_reg, hit_count_next;
  logic                    trigger_reg, trigger_next;
  logic                    armed_reg, armed_next;
  logic                    fired_reg, fired_next;

  logic                    arm_rise, arm_fall;
  logic                    load_cfg;
  logic                    match, hit;
  logic [DATA_WIDTH-1:0]   diff_bits;
  logic [CNT_WIDTH-1:0]    target_eff;
  logic [CNT_WIDTH-1:0]    hit_count_inc;
  logic [CNT_WIDTH:0]      hit_sum;
  logic                    count_reached;
  logic                    entering_fired;

  // Per-bit masked mismatch; the word matches when no compared bit differs.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_cmp
    assign diff_bits[gi] = (probe_q_reg[gi] ^ match_val_l_reg[gi]) & match_mask_l_reg[gi];
  end

  assign match    = ~|diff_bits;
  assign hit      = edge_mode_l_reg ? (match & ~match_prev_reg) : match;
  assign arm_rise = arm & ~arm_q_reg;
  assign arm_fall = ~arm & arm_q_reg;

  assign target_eff    = (count_target_l_reg == '0) ? CNT_WIDTH'(1) : count_target_l_reg;
  assign hit_count_inc = (&hit_count_reg) ? hit_count_reg : hit_count_reg + CNT_WIDTH'(1);
  // Compare on the unsaturated sum so a saturated counter still qualifies.
  assign hit_sum       = {1'b0, hit_count_reg} + (CNT_WIDTH+1)'(1);
  assign count_reached = hit_sum >= {1'b0, target_eff};

  // State and datapath register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg          <= IDLE;
      probe_q_reg        <= '0;
      arm_q_reg          <= 1'b0;
      match_prev_reg     <= 1'b1;
      match_val_l_reg    <= '0;
      match_mask_l_reg   <= '0;
      edge_mode_l_reg    <= 1'b0;
      count_target_l_reg <= '0;
      delay_l_reg        <= '0;
      dly_cnt_reg        <= '0;
      hit_count_reg      <= '0;
      trigger_reg        <= 1'b0;
      armed_reg          <= 1'b0;
      fired_reg          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      probe_q_reg   <= probe;
      arm_q_reg     <= arm;
      dly_cnt_reg   <= dly_cnt_next;
      hit_count_reg <= hit_count_next;
      trigger_reg   <= trigger_next;
      armed_reg     <= armed_next;
      fired_reg     <= fired_next;
      // Forcing match_prev high at arm time keeps a match already present from counting as an edge.
      match_prev_reg <= load_cfg ? 1'b1 : match;
      if (load_cfg) begin
        match_val_l_reg    <= match_val;
        match_mask_l_reg   <= match_mask;
        edge_mode_l_reg    <= edge_mode;
        count_target_l_reg <= count_target;
        delay_l_reg        <= delay;
      end
    end
  end

  // Next-state logic; disarm outranks force, force outranks a hit.
  always_comb begin
    state_next     = state_reg;
    dly_cnt_next   = dly_cnt_reg;
    hit_count_next = hit_count_reg;
    load_cfg       = 1'b0;
    if (arm_fall) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arm_rise) begin
            load_cfg       = 1'b1;
            hit_count_next = '0;
            state_next     = ARMED;
          end
        end
        ARMED: begin
          if (force_trig) begin
            state_next = FIRED;
          end else if (hit) begin
            hit_count_next = hit_count_inc;
            if (count_reached) begin
              if (delay_l_reg == '0) begin
                state_next = FIRED;
              end else begin
                dly_cnt_next = delay_l_reg;
                state_next   = DELAY;
              end
            end
          end
        end
        DELAY: begin
          if (force_trig || (dly_cnt_reg == CNT_WIDTH'(1))) begin
            state_next = FIRED;
          end else begin
            dly_cnt_next = dly_cnt_reg - CNT_WIDTH'(1);
          end
        end
        FIRED: begin
          state_next = FIRED;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so trigger rises on the edge that enters FIRED.
  always_comb begin
    trigger_next = (state_next == FIRED);
    fired_next   = (state_next == FIRED);
    armed_next   = (state_next == ARMED) || (state_next == DELAY);
  end

  assign entering_fired = (state_next == FIRED) && (state_reg != FIRED);

  assign trigger   = trigger_reg;
  assign armed     = armed_reg;
  assign fired     = fired_reg;
  assign hit_count = hit_count_reg;

`ifdef TRIG_TIMESTAMP_EN
  logic [31:0] ts_cnt_reg, ts_cnt_next;
  logic [31:0] trig_time_reg;

  // Cycle counter restarts at the arm edge, so the latched value is cycles elapsed since arm.
  assign ts_cnt_next = load_cfg ? 32'd0 : ts_cnt_reg + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt_reg    <= 32'd0;
      trig_time_reg <= 32'd0;
    end else begin
      ts_cnt_reg <= ts_cnt_next;
      if (load_cfg) begin
        trig_time_reg <= 32'd0;
      end else if (entering_fired) begin
        trig_time_reg <= ts_cnt_next;
      end
    end
  end

  assign trig_time = trig_time_reg;
`else
  logic unused_fire_flag;
  assign unused_fire_flag = entering_fired;
  assign trig_time        = 32'd0;
`endif

endmodule

// File: tb/tb_trig_gen.sv
// Directed bench for trig_gen: expectations are queued per cycle and a negedge monitor compares them.
module tb_trig_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] probe;
  logic        arm;
  logic        force_trig;
  logic [63:0] match_val;
  logic [63:0] match_mask;
  logic        edge_mode;
  logic [15:0] count_target;
  logic [15:0] delay;
  logic        trigger;
  logic        armed;
  logic        fired;
  logic [15:0] hit_count;
  logic [31:0] trig_time;

  always #5 clk = ~clk;

  trig_gen #(.DATA_WIDTH(64), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .probe(probe), .arm(arm), .force_trig(force_trig),
    .match_val(match_val), .match_mask(match_mask), .edge_mode(edge_mode),
    .count_target(count_target), .delay(delay), .trigger(trigger), .armed(armed),
    .fired(fired), .hit_count(hit_count), .trig_time(trig_time)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        trig;
    logic        armd;
    logic        fird;
    logic [15:0] hc;
    logic [31:0] tt;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic expect_at(input int c, input string nm, input logic t, input logic a,
                           input logic f, input logic [15:0] h, input logic [31:0] tt);
    exp_t e;
    e.cyc = c; e.name = nm; e.trig = t; e.armd = a; e.fird = f; e.hc = h; e.tt = tt;
    sb.push_back(e);
  endtask

  // Expected trig_time: edges from the arm edge to the firing edge, or 0 without the timestamp build.
  function automatic logic [31:0] ts(input int d);
`ifdef TRIG_TIMESTAMP_EN
    return 32'(d);
`else
    return (d < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        checks++;
        if (sb[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", sb[i].name, sb[i].cyc, cyc);
        end else if ({trigger, armed, fired, hit_count, trig_time} !==
                     {sb[i].trig, sb[i].armd, sb[i].fird, sb[i].hc, sb[i].tt}) begin
          errors++;
          $display("FAIL %s cyc=%0d: got trig=%b armed=%b fired=%b hit_count=%0d trig_time=%0d, want trig=%b armed=%b fired=%b hit_count=%0d trig_time=%0d",
                   sb[i].name, cyc, trigger, armed, fired, hit_count, trig_time,
                   sb[i].trig, sb[i].armd, sb[i].fird, sb[i].hc, sb[i].tt);
        end else begin
          $display("ok   %s cyc=%0d trig=%b armed=%b fired=%b hit_count=%0d trig_time=%0d",
                   sb[i].name, cyc, trigger, armed, fired, hit_count, trig_time);
        end
        sb.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [63:0] v, input logic [63:0] m, input logic em,
                     input logic [15:0] ct, input logic [15:0] d);
    match_val = v; match_mask = m; edge_mode = em; count_target = ct; delay = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int b;
    rst = 1'b0; probe = '0; arm = 1'b0; force_trig = 1'b0;
    match_val = '0; match_mask = '0; edge_mode = 1'b0; count_target = '0; delay = '0;
    tick(1);
    expect_at(cyc + 1, "reset", 0, 0, 0, 16'd0, 32'd0);
    tick(2);
    rst = 1'b1;
    tick(2);

    // Level match, count 1, no delay: probe set at a+1 -> trigger after edge a+3
    cfg(64'h5A, 64'hFF, 1'b0, 16'd1, 16'd0);
    a = cyc; arm = 1'b1;
    tick(1);
    probe = 64'h1234_5678_9ABC_DE5A;
    expect_at(a + 1, "lvl_armed", 0, 1, 0, 16'd0, 32'd0);
    expect_at(a + 2, "lvl_pre", 0, 1, 0, 16'd0, 32'd0);
    expect_at(a + 3, "lvl_fire", 1, 0, 1, 16'd1, ts(2));
    tick(2);
    probe = '0; arm = 1'b0;
    expect_at(a + 4, "lvl_disarm", 0, 0, 0, 16'd1, ts(2));
    tick(3);

    // Occurrence count 3 over five isolated matches
    cfg(64'h5A, 64'hFF, 1'b0, 16'd3, 16'd0);
    a = cyc; arm = 1'b1;
    tick(1);
    expect_at(a + 6, "cnt_two", 0, 1, 0, 16'd2, 32'd0);
    expect_at(a + 7, "cnt_fire", 1, 0, 1, 16'd3, ts(6));
    expect_at(a + 12, "cnt_hold", 1, 0, 1, 16'd3, ts(6));
    for (int i = 0; i < 5; i++) begin
      probe = 64'h5A; tick(1);
      probe = '0;     tick(1);
    end
    tick(1);
    arm = 1'b0;
    expect_at(a + 13, "cnt_disarm", 0, 0, 0, 16'd3, ts(6));
    tick(3);

    // Edge mode: match present at arm time is not an edge
    cfg(64'h5A, 64'hFF, 1'b1, 16'd1, 16'd0);
    probe = 64'hFFFF_0000_0000_005A;
    tick(2);
    a = cyc; arm = 1'b1;
    tick(10);
    expect_at(a + 10, "edge_held", 0, 1, 0, 16'd0, 32'd0);
    probe = '0;
    tick(1);
    probe = 64'h5A;
    expect_at(a + 12, "edge_pre", 0, 1, 0, 16'd0, 32'd0);
    expect_at(a + 13, "edge_fire", 1, 0, 1, 16'd1, ts(12));
    tick(2);
    arm = 1'b0; probe = '0;
    expect_at(a + 14, "edge_disarm", 0, 0, 0, 16'd1, ts(12));
    tick(3);

    // Delay 4 with a continuously matching probe; fire 7 edges after arm
    cfg(64'h5A, 64'hFF, 1'b0, 16'd1, 16'd4);
    probe = '0;
    a = cyc; arm = 1'b1;
    tick(2);
    probe = 64'h5A;
    expect_at(a + 7, "dly_pre", 0, 1, 0, 16'd1, 32'd0);
    expect_at(a + 8, "dly_fire", 1, 0, 1, 16'd1, ts(7));
    expect_at(a + 10, "dly_hold", 1, 0, 1, 16'd1, ts(7));
    tick(8);
    arm = 1'b0; probe = '0;
    expect_at(a + 11, "dly_disarm", 0, 0, 0, 16'd1, ts(7));
    tick(3);

    // Force together with disarm: disarm wins
    cfg(64'h5A, 64'hFF, 1'b0, 16'd1, 16'd0);
    probe = '0;
    a = cyc; arm = 1'b1;
    tick(2);
    force_trig = 1'b1; arm = 1'b0;
    expect_at(a + 2, "pri_armed", 0, 1, 0, 16'd0, 32'd0);
    expect_at(a + 3, "pri_fall", 0, 0, 0, 16'd0, 32'd0);
    expect_at(a + 4, "pri_idle", 0, 0, 0, 16'd0, 32'd0);
    tick(2);
    force_trig = 1'b0;

    // Force alone while armed with no match
    b = cyc; arm = 1'b1;
    tick(1);
    force_trig = 1'b1;
    expect_at(b + 1, "frc_armed", 0, 1, 0, 16'd0, 32'd0);
    expect_at(b + 2, "frc_fire", 1, 0, 1, 16'd0, ts(1));
    tick(1);
    force_trig = 1'b0; arm = 1'b0;
    expect_at(b + 3, "frc_disarm", 0, 0, 0, 16'd0, ts(1));
    tick(3);

    // Asynchronous reset in the middle of a delay
    cfg(64'h5A, 64'hFF, 1'b0, 16'd1, 16'd10);
    probe = '0;
    a = cyc; arm = 1'b1;
    tick(1);
    probe = 64'h5A;
    expect_at(a + 4, "rst_pre", 0, 1, 0, 16'd1, 32'd0);
    tick(4);
    rst = 1'b0;
    expect_at(a + 5, "rst_async", 0, 0, 0, 16'd0, 32'd0);
    tick(2);
    rst = 1'b1; arm = 1'b0; probe = '0;
    expect_at(a + 8, "rst_after", 0, 0, 0, 16'd0, 32'd0);
    tick(4);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
